// File: rtl/uart_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_pkg
//   Shared definitions for the UART receive buffer: data width, default
//   FIFO geometry and error-counter width, and the classification of a
//   captured receiver event.
// ---------------------------------------------------------------------------
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_ERR_CNT_W = 8;

  // What a single rxDone rising edge turned out to be.
  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_GOOD = 2'd1,
    EVT_ERR  = 2'd2
  } rx_evt_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
//   Generic single-clock first-word-fall-through FIFO.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset
//     i_push    - write i_data (accepted when not full, or when popping)
//     i_pop     - pop the head entry (ignored while empty)
//     i_data    - write data
//     o_data    - head entry, all zeros while empty
//     o_empty   - no entries held (registered)
//     o_full    - DEPTH entries held (registered)
//     o_count   - occupancy 0..DEPTH (registered)
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_W-1:0]     i_data,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [ADDR_WIDTH:0]   o_count
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_empty;
  logic                  r_full;

  logic                  w_pop;
  logic                  w_push;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // Qualify requests and compute next occupancy.
  always_comb begin
    w_pop  = i_pop & ~r_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    w_push = i_push & (~r_full | w_pop);
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (ADDR_WIDTH + 1)'(1);
      2'b01:   w_count_nxt = r_count - (ADDR_WIDTH + 1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and registered occupancy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {ADDR_WIDTH{1'b0}};
      r_rd_ptr <= {ADDR_WIDTH{1'b0}};
      r_count  <= {(ADDR_WIDTH + 1){1'b0}};
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == {(ADDR_WIDTH + 1){1'b0}});
      r_full  <= (w_count_nxt == FULL_CNT);
    end
  end

  assign o_data  = r_empty ? {DATA_W{1'b0}} : r_mem[r_rd_ptr];
  assign o_empty = r_empty;
  assign o_full  = r_full;
  assign o_count = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive buffer behind the Uart8 receiver. One byte is captured per rxDone
//   rising edge; frames flagged with rxErr are dropped and counted, good
//   bytes go into a FWFT FIFO read by the host.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset
//     rxDone    - byte complete (level, may persist)
//     rxErr     - framing error, sampled with rxDone
//     rxByte    - received byte, sampled with rxDone
//     rdEn      - host pops the head entry
//     rdData    - head entry, 8'h00 while empty
//     empty/full/count - FIFO occupancy status
//     overrun   - sticky: good byte dropped because the FIFO was full
//     errCount  - saturating count of frames dropped for rxErr
//     clrFlags  - synchronous clear of overrun and errCount
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_W,
  parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxDone,
  input  logic                   rxErr,
  input  logic [UART_DATA_W-1:0] rxByte,
  input  logic                   rdEn,
  output logic [UART_DATA_W-1:0] rdData,
  output logic                   empty,
  output logic                   full,
  output logic [ADDR_WIDTH:0]    count,
  output logic                   overrun,
  output logic [ERR_CNT_W-1:0]   errCount,
  input  logic                   clrFlags
);

  logic                 r_rx_done_prev;
  logic                 r_overrun;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  rx_evt_e              w_evt_kind;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_writable;
  logic                 w_push;
  logic                 w_overrun_evt;

  // Classify the current cycle's receiver event and decide push/overrun.
  always_comb begin
    if (rxDone & ~r_rx_done_prev) begin
      w_evt_kind = rxErr ? EVT_ERR : EVT_GOOD;
    end else begin
      w_evt_kind = EVT_NONE;
    end
    w_pop         = rdEn & ~w_empty;
    w_writable    = ~w_full | w_pop;
    w_push        = (w_evt_kind == EVT_GOOD) &  w_writable;
    w_overrun_evt = (w_evt_kind == EVT_GOOD) & ~w_writable;
  end

  // Edge-detect history and host-visible statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Held high through reset so a persisting rxDone is not a new byte.
      r_rx_done_prev <= 1'b1;
      r_overrun      <= 1'b0;
      r_err_cnt      <= {ERR_CNT_W{1'b0}};
    end else begin
      r_rx_done_prev <= rxDone;

      // A new overrun wins over a coincident clear.
      if (w_overrun_evt) begin
        r_overrun <= 1'b1;
      end else if (clrFlags) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end

      case (w_evt_kind)
        EVT_ERR: begin
          if (clrFlags) begin
            r_err_cnt <= ERR_CNT_W'(1);
          end else if (r_err_cnt != {ERR_CNT_W{1'b1}}) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
          end else begin
            r_err_cnt <= r_err_cnt;
          end
        end
        default: begin
          if (clrFlags) begin
            r_err_cnt <= {ERR_CNT_W{1'b0}};
          end else begin
            r_err_cnt <= r_err_cnt;
          end
        end
      endcase
    end
  end

  uart_sync_fifo #(
    .DATA_W     (UART_DATA_W),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (rdEn),
    .i_data  (rxByte),
    .o_data  (rdData),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (count)
  );

  assign empty    = w_empty;
  assign full     = w_full;
  assign overrun  = r_overrun;
  assign errCount = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo. A queue-based reference model is
//   advanced once per clock from the inputs applied in that cycle.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxByte;
  logic       rdEn;
  logic       clrFlags;
  logic [7:0] rdData;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic [7:0] errCount;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [7:0] m_q[$];
  int         m_err;
  bit         m_ovr;
  bit         m_prev;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16), .ADDR_WIDTH(4), .ERR_CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxDone   (rxDone),
    .rxErr    (rxErr),
    .rxByte   (rxByte),
    .rdEn     (rdEn),
    .rdData   (rdData),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overrun  (overrun),
    .errCount (errCount),
    .clrFlags (clrFlags)
  );

  // Advance the model with the current inputs, then one clock (sample at +1).
  task automatic tick();
    bit evt;
    bit pop;
    if (rst) begin
      m_q.delete();
      m_err  = 0;
      m_ovr  = 1'b0;
      m_prev = 1'b1;
    end else begin
      evt = rxDone && !m_prev;
      pop = rdEn && (m_q.size() > 0);
      if (clrFlags) begin
        m_ovr = 1'b0;
        m_err = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (evt && rxErr) begin
        m_err = (m_err < 255) ? m_err + 1 : 255;
      end else if (evt) begin
        if (m_q.size() < 16) m_q.push_back(rxByte);
        else m_ovr = 1'b1;
      end
      m_prev = rxDone;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic err);
    rxDone = 1'b1; rxByte = b; rxErr = err;
    tick();
    rxDone = 1'b0; rxErr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; rxDone = 1'b1; rxErr = 1'b0; rxByte = 8'h3C;
    rdEn = 1'b0; clrFlags = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (empty !== 1'b1 || count !== 5'd0 || errCount !== 8'd0 || rdData !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_hold: empty=%b count=%0d errCount=%0d rdData=%h, want 1/0/0/00",
               empty, count, errCount, rdData);
    end
    rxDone = 1'b0;
    tick();
  endtask

  task automatic test_order();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hD6; exp_b[1] = 8'h6B; exp_b[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      rxDone = 1'b1; rxByte = exp_b[i];
      tick();
      if (i == 0) begin
        n_cmp++;
        if (empty !== 1'b0 || rdData !== 8'hD6) begin
          n_bad++;
          $display("FAIL first_latency: empty=%b rdData=%h, want 0/d6", empty, rdData);
        end
      end
      rxDone = 1'b0;
      tick();
    end
    rdEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rdData !== exp_b[i]) begin
        n_bad++;
        $display("FAIL order_read%0d: rdData=%h, want %h", i, rdData, exp_b[i]);
      end
      tick();
    end
    rdEn = 1'b0;
    n_cmp++;
    if (empty !== 1'b1 || rdData !== 8'h00) begin
      n_bad++;
      $display("FAIL order_drained: empty=%b rdData=%h, want 1/00", empty, rdData);
    end
  endtask

  task automatic test_hold();
    rxDone = 1'b1; rxByte = 8'hA5;
    repeat (10) tick();
    rxDone = 1'b0;
    tick();
    n_cmp++;
    if (count !== 5'd1 || rdData !== 8'hA5) begin
      n_bad++;
      $display("FAIL hold_single: count=%0d rdData=%h, want 1/a5", count, rdData);
    end
    rdEn = 1'b1; tick(); rdEn = 1'b0;
  endtask

  task automatic test_full_overrun();
    logic [7:0] sent [17];
    for (int i = 0; i < 17; i++) begin
      sent[i] = 8'($urandom);
      send(sent[i], 1'b0);
    end
    n_cmp++;
    if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL full_overrun: full=%b count=%0d overrun=%b, want 1/16/1", full, count, overrun);
    end
    rdEn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (rdData !== sent[i]) begin
        n_bad++;
        $display("FAIL full_read%0d: rdData=%h, want %h", i, rdData, sent[i]);
      end
      tick();
    end
    rdEn = 1'b0;
    n_cmp++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_bad++;
      $display("FAIL full_drained: empty=%b count=%0d, want 1/0", empty, count);
    end
    clrFlags = 1'b1; tick(); clrFlags = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_clear: overrun=%b, want 0", overrun);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] sent [40];
    int wr_idx = 0;
    int rd_idx = 0;
    int cyc = 0;
    while (rd_idx < 40 && cyc < 400) begin
      if (!rxDone && wr_idx < 40) begin
        sent[wr_idx] = 8'($urandom);
        rxDone = 1'b1; rxByte = sent[wr_idx];
        wr_idx++;
      end else begin
        rxDone = 1'b0;
      end
      rdEn = (m_q.size() >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
      if (rdEn && m_q.size() > 0) begin
        n_cmp++;
        if (rdData !== sent[rd_idx]) begin
          n_bad++;
          $display("FAIL wrap_read%0d: rdData=%h, want %h", rd_idx, rdData, sent[rd_idx]);
        end
        rd_idx++;
      end
      tick();
      cyc++;
    end
    rxDone = 1'b0; rdEn = 1'b0;
    tick();
    n_cmp++;
    if (rd_idx != 40 || empty !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_done: read %0d empty=%b, want 40/1", rd_idx, empty);
    end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 16; i++) send(8'($urandom), 1'b0);
    rxDone = 1'b1; rxByte = 8'h55; rdEn = 1'b1;
    tick();
    rxDone = 1'b0; rdEn = 1'b0;
    n_cmp++;
    if (count !== 5'd16 || full !== 1'b1 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL full_push_pop: count=%0d full=%b overrun=%b, want 16/1/0", count, full, overrun);
    end
    rdEn = 1'b1;
    repeat (15) tick();
    n_cmp++;
    if (rdData !== 8'h55 || count !== 5'd1) begin
      n_bad++;
      $display("FAIL full_push_pop_tail: rdData=%h count=%0d, want 55/1", rdData, count);
    end
    tick();
    rxDone = 1'b1; rxByte = 8'h9E; rdEn = 1'b1;
    tick();
    rxDone = 1'b0; rdEn = 1'b0;
    n_cmp++;
    if (count !== 5'd1 || rdData !== 8'h9E) begin
      n_bad++;
      $display("FAIL empty_push_pop: count=%0d rdData=%h, want 1/9e", count, rdData);
    end
    rdEn = 1'b1; tick(); rdEn = 1'b0;
  endtask

  task automatic test_errors();
    repeat (3) send(8'($urandom), 1'b1);
    n_cmp++;
    if (errCount !== 8'd3 || empty !== 1'b1) begin
      n_bad++;
      $display("FAIL err_three: errCount=%0d empty=%b, want 3/1", errCount, empty);
    end
    repeat (300) send(8'($urandom), 1'b1);
    n_cmp++;
    if (errCount !== 8'd255) begin
      n_bad++;
      $display("FAIL err_saturate: errCount=%0d, want 255", errCount);
    end
    rxDone = 1'b1; rxErr = 1'b1; clrFlags = 1'b1;
    tick();
    rxDone = 1'b0; rxErr = 1'b0; clrFlags = 1'b0;
    tick();
    n_cmp++;
    if (errCount !== 8'd1) begin
      n_bad++;
      $display("FAIL err_clear_race: errCount=%0d, want 1", errCount);
    end
    clrFlags = 1'b1; tick(); clrFlags = 1'b0;
    n_cmp++;
    if (errCount !== 8'd0) begin
      n_bad++;
      $display("FAIL err_clear: errCount=%0d, want 0", errCount);
    end
  endtask

  task automatic test_random();
    logic [23:0] got;
    logic [23:0] want;
    for (int c = 0; c < 400; c++) begin
      rxDone   = 1'($urandom_range(0, 1));
      rxErr    = ($urandom_range(0, 7) == 0);
      rxByte   = 8'($urandom);
      rdEn     = ($urandom_range(0, 3) == 0);
      clrFlags = ($urandom_range(0, 31) == 0);
      tick();
      got  = {count, rdData, empty, full, overrun, errCount[6:0]};
      want = {5'(m_q.size()), (m_q.size() > 0) ? m_q[0] : 8'h00,
              m_q.size() == 0, m_q.size() == 16, m_ovr, 7'(m_err)};
      n_cmp++;
      if (got !== want || errCount[7] !== (m_err > 127)) begin
        n_bad++;
        $display("FAIL random_c%0d: cnt/data/e/f/ovr/err got %h err=%0d, want %h err=%0d",
                 c, got, errCount, want, m_err);
      end
    end
    rxDone = 1'b0; rxErr = 1'b0; rdEn = 1'b0; clrFlags = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0 || errCount !== 8'd0) begin
      n_bad++;
      $display("FAIL async_reset: count=%0d empty=%b overrun=%b errCount=%0d, want 0/1/0/0",
               count, empty, overrun, errCount);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (empty !== 1'b1 || rdData !== 8'h00) begin
      n_bad++;
      $display("FAIL after_reset: empty=%b rdData=%h, want 1/00", empty, rdData);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_hold();
    test_full_overrun();
    test_wrap();
    test_full_simul();
    test_errors();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
